// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses instruction memory and fills IF/ID.
// Memory reads are combinational, so the word for ReadAddress is captured on the next edge.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] MEM_BYTES = 32'h0000_0100
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] ReadAddress,
  input  logic [31:0] Instruction,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {StBoot, StRun, StFault} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_instruction_q, id_instruction_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Next-state: redirect > range check > flush > stall > normal fetch while running.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    id_instruction_d = id_instruction_q;
    id_pc_plus4_d    = id_pc_plus4_q;
    id_valid_d       = id_valid_q;
    fetch_count_d    = fetch_count_q;

    unique case (state_q)
      StBoot: begin
        state_d = StRun;
      end
      StRun: begin
        if (redirect_valid) begin
          id_instruction_d = 32'h0;
          id_pc_plus4_d    = 32'h0;
          id_valid_d       = 1'b0;
          if (redirect_target[1:0] == 2'b00) begin
            pc_d = redirect_target;
          end else begin
            state_d = StFault;
          end
        end else if (pc_q >= MEM_BYTES) begin
          id_instruction_d = 32'h0;
          id_pc_plus4_d    = 32'h0;
          id_valid_d       = 1'b0;
          state_d          = StFault;
        end else if (flush) begin
          id_instruction_d = 32'h0;
          id_pc_plus4_d    = 32'h0;
          id_valid_d       = 1'b0;
          if (!stall) begin
            pc_d = pc_plus4;
          end
        end else if (!stall) begin
          id_instruction_d = Instruction;
          id_pc_plus4_d    = pc_plus4;
          id_valid_d       = 1'b1;
          pc_d             = pc_plus4;
          fetch_count_d    = fetch_count_q + 32'd1;
        end
      end
      StFault: begin
        // Frozen until reset; IF/ID already holds a bubble from the faulting cycle.
      end
      default: begin
        state_d = StFault;
      end
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= StBoot;
      pc_q             <= RESET_PC;
      id_instruction_q <= 32'h0;
      id_pc_plus4_q    <= 32'h0;
      id_valid_q       <= 1'b0;
      fetch_count_q    <= 32'h0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      id_instruction_q <= id_instruction_d;
      id_pc_plus4_q    <= id_pc_plus4_d;
      id_valid_q       <= id_valid_d;
      fetch_count_q    <= fetch_count_d;
    end
  end

  assign ReadAddress    = pc_q;
  assign id_instruction = id_instruction_q;
  assign id_pc_plus4    = id_pc_plus4_q;
  assign id_valid       = id_valid_q;
  assign fetch_fault    = (state_q == StFault);
  assign fetch_count    = fetch_count_q;

endmodule
